fft8_twiddle_sequencer: RTL and testbench
=========================================

# fft8_twiddle_sequencer

Address-generating initiator for the 8-point FFT twiddle ROM (`twiddle_rom_8pt`, 2-bit address, registered 1-cycle read, 32-bit IEEE 754 real/imag).
On `start` it walks all 3 radix-2 DIT stages × 4 butterflies and drives the matching ROM address for each butterfly. It captures the returned twiddle and presents one butterfly descriptor at a time (operand indices plus twiddle) to the downstream butterfly datapath over a valid/ready handshake.

## Interface
- `INVERSE`, default 0: when 1, emit conjugate twiddles for the IFFT.
- `clk` in, 1: clock; all state updates on its rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: begin a 12-butterfly pass; honoured only in IDLE.
- `busy` out, 1: high from the cycle after `start` is accepted until DONE is left.
- `done` out, 1: one-cycle pulse after the last butterfly handshake.
- `rom_addr` out, 2: twiddle ROM address.
- `rom_real` in, 32: ROM real output, valid one cycle after the address.
- `rom_imag` in, 32: ROM imaginary output, valid one cycle after the address.
- `bf_valid` out, 1: descriptor valid.
- `bf_ready` in, 1: downstream accepts the descriptor.
- `bf_stage` out, 2: stage 0..2.
- `bf_idx_a` out, 3: top operand index.
- `bf_idx_b` out, 3: bottom operand index.
- `bf_w_real` out, 32: twiddle, real part.
- `bf_w_imag` out, 32: twiddle, imaginary part.

## Operation
- Counter `cnt`, 4 bits, range 0..11. Derived fields: stage `s = cnt[3:2]`, butterfly `j = cnt[1:0]`, `half = 1<<s`, `g = j>>s`, `p = j & (half-1)`.
- Operand indices: `a = 2*half*g + p`, `b = a + half`.
- Twiddle exponent: `e = p * (4>>s)`, always in 0..3. `rom_addr = e`.
- Required sequence:
  - Stage 0: (0,1,W0) (2,3,W0) (4,5,W0) (6,7,W0).
  - Stage 1: (0,2,W0) (1,3,W2) (4,6,W0) (5,7,W2).
  - Stage 2: (0,4,W0) (1,5,W1) (2,6,W2) (3,7,W3).
- FSM states: IDLE, FETCH, LOAD, OUT, DONE.
  - IDLE: `start` → `cnt`=0, go to FETCH.
  - FETCH: `rom_addr` = e(`cnt`); the ROM samples at the closing edge. Go to LOAD.
  - LOAD: ROM data is valid. At the closing edge, register `bf_w_real`/`bf_w_imag`, `bf_stage`, `bf_idx_a`, `bf_idx_b`; set `bf_valid`=1. Go to OUT.
  - OUT: hold all `bf_*` stable while `bf_ready`=0. On `bf_valid && bf_ready`: clear `bf_valid`. If `cnt`==11 go to DONE, else `cnt`+1 and go to FETCH.
  - DONE: `done`=1 for this cycle only. Go to IDLE.
- `rom_addr` is registered, updated on entry to FETCH, and held through LOAD and OUT.
- INVERSE=1: `bf_w_imag` = `rom_imag` with bit 31 inverted, except when `rom_imag[30:0]`==0 (zero stays +0). `bf_w_real` is unchanged.
- `start` while busy is ignored. There is no queuing.

## Timing
- Reset values: `busy`=0, `done`=0, `bf_valid`=0, `rom_addr`=0, `bf_stage`=0, `bf_idx_a`=0, `bf_idx_b`=0, `bf_w_real`=0, `bf_w_imag`=0; state IDLE, `cnt`=0.
- `start` sampled at edge 0 → FETCH in cycle 1, LOAD in cycle 2, `bf_valid` high in cycle 3. First-descriptor latency is 3 cycles.
- With `bf_ready` held 1: one descriptor every 3 cycles.
- Full pass: 36 cycles from `start` to the last handshake; `done` high in cycle 37; `busy` low from cycle 38.
- Backpressure: any number of `bf_ready`=0 cycles stretches OUT with no loss, duplication, or change in outputs.
- `bf_ready` asserted while `bf_valid`=0 has no effect.
- `rst_n` low at any time, including mid-pass or during OUT with `bf_valid`=1: all outputs go to their reset values immediately, without waiting for `clk`. After release the block waits in IDLE for a new `start`.
- `start` high in the DONE cycle is ignored. `start` in the first IDLE cycle after DONE is accepted.

## Test plan
- Reset then `start` with `bf_ready`=1 and a ROM model attached → 12 descriptors in the order listed under Operation.
  - e.g. descriptor 9: stage 2, a=1, b=5, W=0x3F3504F3/0xBF3504F3.
  - e.g. descriptor 11: a=3, b=7, W=0xBF3504F3/0xBF3504F3.
  - `done` pulses in cycle 37.
- Cycle-accurate check with `bf_ready`=1: `bf_valid` high in cycles 3, 6, …, 36 only; `rom_addr` in FETCH cycles = 0,0,0,0, 0,2,0,2, 0,1,2,3.
- Random `bf_ready` stalls (up to 5 cycles) → identical 12-descriptor sequence; all `bf_*` and `rom_addr` stable throughout each stall; `done` occurs after exactly 12 handshakes.
- INVERSE=1 pass → W2 imag = 0x3F800000, W1 imag = 0x3F3504F3, W3 imag = 0x3F3504F3, W0 imag = 0x00000000; real parts match INVERSE=0.
- `rst_n` pulsed low during the stage-1 OUT state → `bf_valid`, `busy`, and `rom_addr` go to 0 asynchronously; a new `start` restarts at stage 0 with (0,1,W0).
- `start` pulsed repeatedly while `busy` → exactly 12 descriptors and one `done`; a `start` one cycle after DONE begins a second full pass.

Source files
------------

// File: rtl/fft8_twiddle_sequencer.sv
// Twiddle-address sequencer for an 8-point radix-2 DIT FFT: walks 3 stages x 4
// butterflies, fetches each twiddle from a 1-cycle ROM and hands out descriptors.
module fft8_twiddle_sequencer #(
  parameter bit INVERSE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  rom_addr,
  input  logic [31:0] rom_real,
  input  logic [31:0] rom_imag,
  output logic        bf_valid,
  input  logic        bf_ready,
  output logic [1:0]  bf_stage,
  output logic [2:0]  bf_idx_a,
  output logic [2:0]  bf_idx_b,
  output logic [31:0] bf_w_real,
  output logic [31:0] bf_w_imag,
  output logic [2:0]  fsm_state
);

  // Handshake: a descriptor transfers on any rising edge where bf_valid and
  // bf_ready are both high; while bf_valid is high and bf_ready is low, every
  // bf_* output and rom_addr holds its value. bf_ready with bf_valid low is ignored.

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, OUT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_inc;
  logic        hs;
  logic [31:0] w_imag_in;

  // Closed forms of e = p*(4>>s) and a = 2*half*g + p, one case per stage.
  function automatic logic [1:0] tw_exp(input logic [3:0] c);
    case (c[3:2])
      2'd1:    tw_exp = {c[0], 1'b0};
      2'd2:    tw_exp = c[1:0];
      default: tw_exp = 2'd0;
    endcase
  endfunction

  function automatic logic [2:0] idx_top(input logic [3:0] c);
    case (c[3:2])
      2'd0:    idx_top = {c[1:0], 1'b0};
      2'd1:    idx_top = {c[1], 1'b0, c[0]};
      default: idx_top = {1'b0, c[1:0]};
    endcase
  endfunction

  function automatic logic [2:0] half_span(input logic [1:0] s);
    case (s)
      2'd0:    half_span = 3'd1;
      2'd1:    half_span = 3'd2;
      default: half_span = 3'd4;
    endcase
  endfunction

  assign cnt_inc   = cnt + 4'd1;
  assign hs        = (state == OUT) && bf_valid && bf_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fsm_state = state;

  // Conjugation flips the sign bit but keeps a zero imaginary part at +0.
  always_comb begin
    w_imag_in = rom_imag;
    if (INVERSE && (rom_imag[30:0] != 31'd0)) begin
      w_imag_in = {~rom_imag[31], rom_imag[30:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = OUT;
      OUT:     if (hs) state_nxt = (cnt == 4'd11) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      rom_addr  <= 2'd0;
      bf_valid  <= 1'b0;
      bf_stage  <= 2'd0;
      bf_idx_a  <= 3'd0;
      bf_idx_b  <= 3'd0;
      bf_w_real <= 32'd0;
      bf_w_imag <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt      <= 4'd0;
            rom_addr <= tw_exp(4'd0);
          end
        end
        LOAD: begin
          bf_w_real <= rom_real;
          bf_w_imag <= w_imag_in;
          bf_stage  <= cnt[3:2];
          bf_idx_a  <= idx_top(cnt);
          bf_idx_b  <= idx_top(cnt) + half_span(cnt[3:2]);
          bf_valid  <= 1'b1;
        end
        OUT: begin
          if (hs) begin
            bf_valid <= 1'b0;
            if (cnt != 4'd11) begin
              cnt      <= cnt_inc;
              rom_addr <= tw_exp(cnt_inc);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft8_twiddle_sequencer.sv
// Bench for fft8_twiddle_sequencer: ROM model, butterfly-order reference model,
// scoreboard compare process and directed timing/backpressure/reset scenarios.
module tb_fft8_twiddle_sequencer;
  localparam int W = 74;  // {e, stage, a, b, w_real, w_imag}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT (forward) ----------------
  logic        start, busy, done, bf_valid, bf_ready;
  logic [1:0]  rom_addr, bf_stage;
  logic [2:0]  bf_idx_a, bf_idx_b, fsm_state;
  logic [31:0] rom_real, rom_imag, bf_w_real, bf_w_imag;

  fft8_twiddle_sequencer #(.INVERSE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_real(rom_real), .rom_imag(rom_imag),
    .bf_valid(bf_valid), .bf_ready(bf_ready), .bf_stage(bf_stage),
    .bf_idx_a(bf_idx_a), .bf_idx_b(bf_idx_b), .bf_w_real(bf_w_real),
    .bf_w_imag(bf_w_imag), .fsm_state(fsm_state)
  );

  // ---------------- DUT (inverse) ----------------
  logic        inv_start, inv_busy, inv_done, inv_bf_valid, inv_bf_ready;
  logic [1:0]  inv_rom_addr, inv_bf_stage;
  logic [2:0]  inv_bf_idx_a, inv_bf_idx_b, inv_fsm_state;
  logic [31:0] inv_rom_real, inv_rom_imag, inv_bf_w_real, inv_bf_w_imag;

  fft8_twiddle_sequencer #(.INVERSE(1'b1)) dut_inv (
    .clk(clk), .rst_n(rst_n), .start(inv_start), .busy(inv_busy), .done(inv_done),
    .rom_addr(inv_rom_addr), .rom_real(inv_rom_real), .rom_imag(inv_rom_imag),
    .bf_valid(inv_bf_valid), .bf_ready(inv_bf_ready), .bf_stage(inv_bf_stage),
    .bf_idx_a(inv_bf_idx_a), .bf_idx_b(inv_bf_idx_b), .bf_w_real(inv_bf_w_real),
    .bf_w_imag(inv_bf_w_imag), .fsm_state(inv_fsm_state)
  );

  // ---------------- twiddle ROM model: W^k = exp(-j*2*pi*k/8) ----------------
  logic [31:0] rom_re [4] = '{32'h3F800000, 32'h3F3504F3, 32'h00000000, 32'hBF3504F3};
  logic [31:0] rom_im [4] = '{32'h00000000, 32'hBF3504F3, 32'hBF800000, 32'hBF3504F3};

  always @(posedge clk) begin
    rom_real     <= rom_re[rom_addr];
    rom_imag     <= rom_im[rom_addr];
    inv_rom_real <= rom_re[inv_rom_addr];
    inv_rom_imag <= rom_im[inv_rom_addr];
  end

  // ---------------- counters and check task ----------------
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_desc [12];
  logic [W-1:0] m_inv  [12];
  logic [1:0]   addr_lit [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2,
                                  2'd0, 2'd1, 2'd2, 2'd3};

  // Butterflies of each stage: groups of 2*span, span pairs per group.
  task automatic build_model();
    int k;
    int span, e, a, b;
    logic [31:0] wi;
    k = 0;
    for (int s = 0; s < 3; s++) begin
      span = 1 << s;
      for (int base = 0; base < 8; base += 2 * span) begin
        for (int p = 0; p < span; p++) begin
          a = base + p;
          b = a + span;
          e = (p * 8 / (2 * span)) % 4;
          wi = rom_im[e];
          m_desc[k] = {e[1:0], s[1:0], a[2:0], b[2:0], rom_re[e], wi};
          if (wi[30:0] != 31'd0) wi[31] = ~wi[31];
          m_inv[k] = {e[1:0], s[1:0], a[2:0], b[2:0], rom_re[e], wi};
          k++;
        end
      end
    end
  endtask

  // ---------------- scoreboard / compare processes ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_qi[$];
  int  hs_cnt = 0;
  int  done_cnt = 0;
  bit  chk_en = 0;
  bit  chk_inv = 0;
  logic [W-1:0] prev_out;
  logic         prev_stall = 1'b0;
  logic [W-1:0] cur_out, cur_inv;
  logic [W-1:0] exp_item;

  assign cur_out = {rom_addr, bf_stage, bf_idx_a, bf_idx_b, bf_w_real, bf_w_imag};
  assign cur_inv = {inv_rom_addr, inv_bf_stage, inv_bf_idx_a, inv_bf_idx_b,
                    inv_bf_w_real, inv_bf_w_imag};

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (prev_stall) check("stall_hold", {bf_valid, cur_out}, {1'b1, prev_out});
      if (bf_valid && bf_ready) begin
        exp_item = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        check("desc", cur_out, exp_item);
        hs_cnt++;
      end
      if (done) begin
        check("done_after_12", hs_cnt, 12);
        done_cnt++;
      end
    end
    prev_stall = bf_valid && !bf_ready;
    prev_out   = cur_out;
  end

  always @(negedge clk) begin
    if (chk_inv && rst_n && inv_bf_valid && inv_bf_ready) begin
      exp_item = (exp_qi.size() != 0) ? exp_qi.pop_front() : '1;
      check("inv_desc", cur_inv, exp_item);
    end
  end

  task automatic load_q();
    exp_q.delete();
    foreach (m_desc[i]) exp_q.push_back(m_desc[i]);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(name, done, 1'b1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n, lows;
    rst_n = 1'b0; start = 1'b0; bf_ready = 1'b1;
    inv_start = 1'b0; inv_bf_ready = 1'b1;
    build_model();

    // Hand-computed pins on the model
    check("model_d9",  m_desc[9],  {2'd1, 2'd2, 3'd1, 3'd5, 32'h3F3504F3, 32'hBF3504F3});
    check("model_d11", m_desc[11], {2'd3, 2'd2, 3'd3, 3'd7, 32'hBF3504F3, 32'hBF3504F3});
    check("model_d5",  m_desc[5],  {2'd2, 2'd1, 3'd1, 3'd3, 32'h00000000, 32'hBF800000});
    check("model_inv_w2", m_inv[10][31:0], 32'h3F800000);
    check("model_inv_w1", m_inv[9][31:0],  32'h3F3504F3);
    check("model_inv_w3", m_inv[11][31:0], 32'h3F3504F3);
    check("model_inv_w0", m_inv[0][31:0],  32'h00000000);
    for (int i = 0; i < 12; i++) check("model_addr", m_desc[i][W-1:W-2], addr_lit[i]);

    repeat (3) step();
    check("rst_fwd", {busy, done, bf_valid, cur_out}, 0);
    check("rst_inv", {inv_busy, inv_done, inv_bf_valid, cur_inv}, 0);
    rst_n = 1'b1;
    step();

    // Pass 1: full-rate, cycle-accurate, both instances
    load_q();
    exp_qi.delete();
    foreach (m_inv[i]) exp_qi.push_back(m_inv[i]);
    hs_cnt = 0; chk_en = 1; chk_inv = 1;
    start = 1'b1; inv_start = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      step();
      start = 1'b0; inv_start = 1'b0;
      check("valid_cycle", bf_valid, (c % 3 == 0) && (c >= 3) && (c <= 36));
      check("busy_cycle", busy, c <= 37);
      check("done_cycle", done, c == 37);
      if ((c % 3 == 1) && (c <= 34)) check("addr_fetch", rom_addr, addr_lit[(c - 1) / 3]);
    end
    check("drained_fwd", exp_q.size(), 0);
    check("drained_inv", exp_qi.size(), 0);
    chk_inv = 0;

    // Pass 2: random stalls, start re-pulsed while busy
    load_q();
    hs_cnt = 0; done_cnt = 0;
    start = 1'b1;
    step();
    n = 0; lows = 0;
    while (done !== 1'b1 && n < 600) begin
      bf_ready = (lows >= 5) ? 1'b1 : ($urandom_range(0, 2) == 0);
      lows = bf_ready ? 0 : lows + 1;
      start = $urandom_range(0, 1);
      step();
      n++;
    end
    check("stall_done_seen", done, 1'b1);
    bf_ready = 1'b1;
    start = 1'b1;            // high during DONE: must be ignored
    step();
    check("start_in_done_ignored", {busy, done}, 2'b00);
    hs_cnt = 0;
    load_q();
    step();                  // start still high in first IDLE cycle: accepted
    check("restart_after_done", busy, 1'b1);
    start = 1'b0;
    wait_done(60, "second_pass_done");
    step();
    check("done_one_cycle", done, 1'b0);
    check("done_count", done_cnt, 2);
    check("drained_stall", exp_q.size(), 0);

    // Pass 3: asynchronous reset during a stage-1 descriptor
    load_q();
    hs_cnt = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(bf_valid === 1'b1 && bf_stage == 2'd1) && n < 60) begin
      step();
      n++;
    end
    check("reached_stage1", {bf_valid, bf_stage}, {1'b1, 2'd1});
    chk_en = 0;
    #1 rst_n = 1'b0;
    #1 check("async_reset", {busy, done, bf_valid, cur_out}, 0);
    step();
    rst_n = 1'b1;
    step();
    check("idle_after_reset", busy, 1'b0);
    load_q();
    hs_cnt = 0;
    chk_en = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (bf_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("restart_first", {bf_valid, bf_stage, bf_idx_a, bf_idx_b}, {1'b1, 2'd0, 3'd0, 3'd1});
    wait_done(60, "reset_pass_done");
    step();
    check("drained_reset", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
